// File: rtl/program_loader_pkg.sv
// Shared types and constants for the program loader front end.
package program_loader_pkg;

    // Loader sequencing states
    typedef enum logic [2:0] {
        RUN,
        ARMED,
        WRITE,
        RELEASE,
        FULL
    } state_e;

    // Flops in each raw-input synchronizer chain
    localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/program_loader_if.sv
// Program-memory write bus driven by the loader.
interface program_loader_if #(
    parameter int unsigned ADDR_W = 5
);
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;

    modport master (output mem_we, mem_addr, mem_wdata);
    modport slave  (input  mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/program_loader_debouncer.sv
// Synchronizer plus stability counter for one raw board input.
// level_o is the accepted level; edge_o pulses for one cycle when it changes.
module button_debouncer
    import program_loader_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter logic        RESET_LEVEL     = 1'b1
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic raw_i,
    output logic level_o,
    output logic edge_o
);

    localparam int unsigned      CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   edge_q, edge_d;
    logic                   sample;

    assign sample  = sync_q[SYNC_STAGES-1];
    assign level_o = level_q;
    assign edge_o  = edge_q;

    // Shift the raw input in and count consecutive samples that disagree with the accepted level
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], raw_i};
        cnt_d   = cnt_q;
        level_d = level_q;
        edge_d  = 1'b0;
        if (sample != level_q) begin
            if (cnt_q == LAST) begin
                level_d = sample;
                cnt_d   = '0;
                edge_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Debouncer state registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q  <= {SYNC_STAGES{RESET_LEVEL}};
            cnt_q   <= '0;
            level_q <= RESET_LEVEL;
            edge_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            edge_q  <= edge_d;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Captures switch bytes on debounced button presses and writes them to
// sequential program-memory addresses while in program mode.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned ADDR_W          = 5,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic                  clock,
    input  logic                  reset_N,
    input  logic                  mode,
    input  logic                  program_clock,
    input  logic [7:0]            io_in,
    program_loader_if.master      mem,
    output logic [ADDR_W:0]       load_count,
    output logic                  full,
    output logic                  loading,
    output logic                  run_start
);

    logic btn_lvl, btn_edge;
    logic mode_lvl, mode_edge;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, full_d;
    logic [7:0]        data_q, data_d;

    button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_LEVEL     (1'b1)
    ) u_btn_deb (
        .clk_i   (clock),
        .rst_n_i (reset_N),
        .raw_i   (program_clock),
        .level_o (btn_lvl),
        .edge_o  (btn_edge)
    );

    button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_LEVEL     (1'b0)
    ) u_mode_deb (
        .clk_i   (clock),
        .rst_n_i (reset_N),
        .raw_i   (mode),
        .level_o (mode_lvl),
        .edge_o  (mode_edge)
    );

    // Next-state logic; leaving program mode follows the debounced mode level
    // rather than its edge, so a fall seen during WRITE is honoured one cycle later.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        count_d   = count_q;
        full_d    = full_q;
        data_d    = data_q;
        run_start = 1'b0;
        case (state_q)
            RUN: begin
                if (mode_edge && mode_lvl) begin
                    state_d = ARMED;
                    addr_d  = '0;
                    count_d = '0;
                    full_d  = 1'b0;
                end
            end
            ARMED: begin
                if (!mode_lvl) begin
                    state_d   = RUN;
                    run_start = 1'b1;
                end else if (btn_edge && !btn_lvl) begin
                    state_d = WRITE;
                    data_d  = io_in;
                end
            end
            WRITE: begin
                count_d = count_q + (ADDR_W+1)'(1);
                if (addr_q == '1) begin
                    state_d = FULL;
                    full_d  = 1'b1;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (!mode_lvl) begin
                    state_d   = RUN;
                    run_start = 1'b1;
                end else if (btn_edge && btn_lvl) begin
                    state_d = ARMED;
                end
            end
            FULL: begin
                if (!mode_lvl) begin
                    state_d   = RUN;
                    run_start = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Loader state, address, count and capture registers
    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            state_q <= RUN;
            addr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            full_q  <= full_d;
            data_q  <= data_d;
        end
    end

    assign mem.mem_we    = (state_q == WRITE);
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = data_q;
    assign load_count    = count_q;
    assign full          = full_q;
    assign loading       = (state_q != RUN);

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: a 32-byte instance and a 4-byte instance,
// both with a 4-cycle debounce.
module tb_program_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mode_s [2];
    logic       btn_s  [2];
    logic [7:0] io_s   [2];

    logic [5:0] lc0;
    logic [2:0] lc1;
    logic       full0, full1, ld0, ld1, rs0, rs1;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int         exp_cnt [2];
    int         depth   [2];
    bit         prog    [2];
    int         exp_rs  [2];
    int         seen_rs [2];
    logic [12:0] q0 [$];
    logic [12:0] q1 [$];

    always #5 clk = ~clk;

    program_loader_if #(.ADDR_W(5)) bus0 ();
    program_loader_if #(.ADDR_W(2)) bus1 ();

    program_loader #(.ADDR_W(5), .DEBOUNCE_CYCLES(4)) dut0 (
        .clock(clk), .reset_N(rst_n), .mode(mode_s[0]), .program_clock(btn_s[0]),
        .io_in(io_s[0]), .mem(bus0), .load_count(lc0), .full(full0),
        .loading(ld0), .run_start(rs0)
    );

    program_loader #(.ADDR_W(2), .DEBOUNCE_CYCLES(4)) dut1 (
        .clock(clk), .reset_N(rst_n), .mode(mode_s[1]), .program_clock(btn_s[1]),
        .io_in(io_s[1]), .mem(bus1), .load_count(lc1), .full(full1),
        .loading(ld1), .run_start(rs1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_write(input int d, input logic [7:0] b);
        if (prog[d] && exp_cnt[d] < depth[d]) begin
            if (d == 0) q0.push_back({5'(exp_cnt[d]), b});
            else        q1.push_back({5'(exp_cnt[d]), b});
            exp_cnt[d]++;
        end
    endtask

    task automatic set_mode(input int d, input bit m);
        if (m && !prog[d]) exp_cnt[d] = 0;
        if (!m && prog[d]) exp_rs[d]++;
        prog[d]   = m;
        mode_s[d] = m;
        tick(12);
    endtask

    task automatic press(input int d, input logic [7:0] b, input int hold, input int rel);
        expect_write(d, b);
        io_s[d]  = b;
        btn_s[d] = 1'b0;
        tick(hold);
        btn_s[d] = 1'b1;
        tick(rel);
    endtask

    task automatic check_status(input int d, input string tag);
        if (d == 0) begin
            check({tag, "_lc0"},   32'(lc0),   32'(exp_cnt[0]));
            check({tag, "_full0"}, 32'(full0), 32'(exp_cnt[0] == depth[0]));
        end else begin
            check({tag, "_lc1"},   32'(lc1),   32'(exp_cnt[1]));
            check({tag, "_full1"}, 32'(full1), 32'(exp_cnt[1] == depth[1]));
        end
    endtask

    // Monitors: every strobe must match the oldest expected write
    always @(negedge clk) begin
        if (bus0.mem_we === 1'b1) begin
            if (q0.size() == 0) begin
                check("unexpected_wr0", {19'b0, bus0.mem_addr, bus0.mem_wdata}, 32'hFFFF_FFFF);
            end else begin
                check("wr0", {19'b0, bus0.mem_addr, bus0.mem_wdata}, {19'b0, q0.pop_front()});
            end
        end
        if (bus1.mem_we === 1'b1) begin
            if (q1.size() == 0) begin
                check("unexpected_wr1", {22'b0, bus1.mem_addr, bus1.mem_wdata}, 32'hFFFF_FFFF);
            end else begin
                check("wr1", {19'b0, 3'b000, bus1.mem_addr, bus1.mem_wdata}, {19'b0, q1.pop_front()});
            end
        end
        if (rs0 === 1'b1) seen_rs[0]++;
        if (rs1 === 1'b1) seen_rs[1]++;
    end

    initial begin
        logic [7:0] seq [19];
        int         k;
        logic [7:0] b;

        seq = '{8'h81, 8'h10, 8'h06, 8'h46, 8'hDA, 8'h0A, 8'h22, 8'h46, 8'hC0, 8'h04,
                8'h04, 8'hA4, 8'h11, 8'hC0, 8'h0D, 8'hFE, 8'h05, 8'h00, 8'hFE};
        depth = '{32, 4};
        for (int d = 0; d < 2; d++) begin
            exp_cnt[d] = 0; prog[d] = 0; exp_rs[d] = 0; seen_rs[d] = 0;
            mode_s[d] = 1'b0; btn_s[d] = 1'b1; io_s[d] = 8'h00;
        end

        // Reset values
        rst_n = 1'b0;
        tick(3);
        check("rst_we0",    32'(bus0.mem_we),    0);
        check("rst_addr0",  32'(bus0.mem_addr),  0);
        check("rst_wdata0", 32'(bus0.mem_wdata), 0);
        check("rst_lc0",    32'(lc0),            0);
        check("rst_full0",  32'(full0),          0);
        check("rst_ld0",    32'(ld0),            0);
        check("rst_rs0",    32'(rs0),            0);
        check("rst_ld1",    32'(ld1),            0);
        rst_n = 1'b1;
        tick(3);

        // Enter program mode on both instances
        set_mode(0, 1'b1);
        set_mode(1, 1'b1);
        check("enter_ld0", 32'(ld0), 1);
        check("enter_ld1", 32'(ld1), 1);

        // First byte also measures press-to-strobe latency (2 + 4 + 1)
        expect_write(0, seq[0]);
        io_s[0]  = seq[0];
        btn_s[0] = 1'b0;
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus0.mem_we === 1'b1) begin
                k = i;
                break;
            end
        end
        check("latency", 32'(k), 7);
        tick(4);
        btn_s[0] = 1'b1;
        tick(10);

        for (int i = 1; i < 19; i++) press(0, seq[i], 10, 10);
        check_status(0, "load19");

        // Bouncy press: three short glitches on each edge
        b = 8'h5C;
        expect_write(0, b);
        io_s[0] = b;
        btn_s[0] = 1'b0; tick(1); btn_s[0] = 1'b1; tick(2);
        btn_s[0] = 1'b0; tick(1); btn_s[0] = 1'b1; tick(1);
        btn_s[0] = 1'b0; tick(2); btn_s[0] = 1'b1; tick(1);
        btn_s[0] = 1'b0; tick(12);
        btn_s[0] = 1'b1; tick(1); btn_s[0] = 1'b0; tick(2);
        btn_s[0] = 1'b1; tick(1); btn_s[0] = 1'b0; tick(1);
        btn_s[0] = 1'b1; tick(2); btn_s[0] = 1'b0; tick(1);
        btn_s[0] = 1'b1; tick(12);

        // Glitch shorter than the debounce window
        io_s[0] = 8'h33;
        btn_s[0] = 1'b0; tick(3); btn_s[0] = 1'b1; tick(12);
        check_status(0, "bounce");

        // Long hold gives a single write, then the next press follows on
        press(0, 8'hA5, 1000, 10);
        press(0, 8'h3C, 10, 10);
        check_status(0, "held");

        // Randomized data and timing
        for (int i = 0; i < 5; i++) begin
            press(0, 8'($urandom), $urandom_range(20, 8), $urandom_range(20, 8));
        end
        check_status(0, "rand");

        // Back to run mode: one run_start, counts held, presses ignored
        set_mode(0, 1'b0);
        check("run_ld0", 32'(ld0), 0);
        check("run_rs0", 32'(seen_rs[0]), 32'(exp_rs[0]));
        press(0, 8'h77, 10, 10);
        check_status(0, "run_hold");

        // Small memory fills, extra presses dropped
        for (int i = 0; i < 6; i++) begin
            press(1, 8'($urandom), $urandom_range(16, 8), $urandom_range(16, 8));
            check_status(1, "fill");
        end
        check("fill_addr1", 32'(bus1.mem_addr), 3);
        set_mode(1, 1'b0);

        // Re-entry clears count and full, writing restarts at address 0
        set_mode(0, 1'b1);
        check_status(0, "reenter");
        set_mode(1, 1'b1);
        check_status(1, "reenter");
        press(0, 8'hE1, 10, 10);
        press(1, 8'h1E, 10, 10);
        check_status(0, "reenter_wr");
        check_status(1, "reenter_wr");

        // Mode fall landing on the WRITE cycle: write completes, then run
        b = 8'h9B;
        expect_write(0, b);
        io_s[0] = b;
        btn_s[0] = 1'b0;
        tick(1);
        mode_s[0] = 1'b0;
        prog[0] = 0;
        exp_rs[0]++;
        tick(12);
        btn_s[0] = 1'b1;
        tick(12);
        check("wfall_ld0", 32'(ld0), 0);
        check("wfall_lc0", 32'(lc0), 32'(exp_cnt[0]));

        // Press accepted together with the mode fall is discarded
        io_s[1] = 8'h66;
        btn_s[1] = 1'b0;
        mode_s[1] = 1'b0;
        prog[1] = 0;
        exp_rs[1]++;
        tick(12);
        btn_s[1] = 1'b1;
        tick(12);
        check("disc_lc1", 32'(lc1), 32'(exp_cnt[1]));
        check("disc_ld1", 32'(ld1), 0);

        // Reset in the middle of a write
        set_mode(0, 1'b1);
        io_s[0] = 8'hC7;
        btn_s[0] = 1'b0;
        k = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (bus0.mem_we === 1'b1) begin
                k = 1;
                break;
            end
        end
        check("mid_we_seen", 32'(k), 1);
        rst_n = 1'b0;
        #1;
        check("mid_we0",    32'(bus0.mem_we),    0);
        check("mid_addr0",  32'(bus0.mem_addr),  0);
        check("mid_wdata0", 32'(bus0.mem_wdata), 0);
        check("mid_lc0",    32'(lc0),            0);
        check("mid_full0",  32'(full0),          0);
        check("mid_ld0",    32'(ld0),            0);
        check("mid_rs0",    32'(rs0),            0);
        exp_cnt[0] = 0;
        exp_cnt[1] = 0;
        tick(2);
        rst_n = 1'b1;
        tick(30);
        check("held_after_rst_ld0", 32'(ld0), 1);
        check("held_after_rst_lc0", 32'(lc0), 0);
        btn_s[0] = 1'b1;
        tick(10);
        press(0, 8'h4D, 10, 10);
        check_status(0, "post_rst");

        set_mode(0, 1'b0);
        tick(20);
        check("q0_empty", 32'(q0.size()), 0);
        check("q1_empty", 32'(q1.size()), 0);
        check("rs_count0", 32'(seen_rs[0]), 32'(exp_rs[0]));
        check("rs_count1", 32'(seen_rs[1]), 32'(exp_rs[1]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop if the stimulus ever stalls
    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
